// File: rtl/sw_cmd_pkg.sv
// Shared types and field positions for the software command decoder.
package sw_cmd_pkg;

  typedef enum logic [3:0] {
    OP_W_RESET        = 4'h0,
    OP_W_CFG_STATIC_0 = 4'h1,
    OP_R_CFG_STATIC_0 = 4'h2,
    OP_W_CFG_ARRAY_0  = 4'h3,
    OP_R_CFG_ARRAY_0  = 4'h4,
    OP_W_CFG_ARRAY_1  = 4'h5,
    OP_R_CFG_ARRAY_1  = 4'h6,
    OP_R_DATA_ARRAY_0 = 4'h7,
    OP_R_DATA_ARRAY_1 = 4'h8,
    OP_R_STATUS       = 4'h9,
    OP_W_EXECUTE      = 4'hA
  } op_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } sw_cmd_state_t;

  // Command word field positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int DEV_MSB = 27;
  localparam int DEV_LSB = 24;
  localparam int PAY_MSB = 23;

  // Highest legal op-code; everything above is rejected
  localparam logic [3:0] OP_MAX = 4'hA;
  localparam int NUM_OPS = 11;

  // Status word bit positions
  localparam int STS_BUSY_BIT    = 31;
  localparam int STS_ERR_BUSY    = 30;
  localparam int STS_ERR_ILLEGAL = 29;
  localparam int STS_LAST_MSB    = 23;
  localparam int STS_LAST_LSB    = 16;
  localparam int STS_CNT_MSB     = 15;

  // Read op-codes wait for the IP and then capture a read-back word
  function automatic logic is_read_op(op_code_t op);
    case (op)
      OP_R_CFG_STATIC_0, OP_R_CFG_ARRAY_0, OP_R_CFG_ARRAY_1,
      OP_R_DATA_ARRAY_0, OP_R_DATA_ARRAY_1, OP_R_STATUS: is_read_op = 1'b1;
      default:                                            is_read_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sw_cmd_decoder.sv
// Software command decoder: accepts a command word, strobes the addressed
// firmware IP, and for read ops captures its read-back word after a fixed latency.
module sw_cmd_decoder
  import sw_cmd_pkg::*;
#(
  parameter int NUM_FW   = 15,
  parameter int READ_LAT = 2
) (
  input  logic                 fw_clk,
  input  logic                 fw_rst_n,
  input  logic [31:0]          sw_write32_0,
  input  logic                 sw_write32_0_wstb,
  input  logic [NUM_FW*32-1:0] fw_read_data32_bus,
  input  logic [NUM_FW*32-1:0] fw_read_status32_bus,
  output logic [NUM_FW-1:0]    fw_dev_id_enable,
  output logic                 fw_op_code_w_reset,
  output logic                 fw_op_code_w_cfg_static_0,
  output logic                 fw_op_code_r_cfg_static_0,
  output logic                 fw_op_code_w_cfg_array_0,
  output logic                 fw_op_code_r_cfg_array_0,
  output logic                 fw_op_code_w_cfg_array_1,
  output logic                 fw_op_code_r_cfg_array_1,
  output logic                 fw_op_code_r_data_array_0,
  output logic                 fw_op_code_r_data_array_1,
  output logic                 fw_op_code_r_status,
  output logic                 fw_op_code_w_execute,
  output logic [23:0]          sw_write24_0,
  output logic [31:0]          sw_read32_0,
  output logic [31:0]          sw_read32_1
);

  localparam int IDX_W = $clog2(NUM_FW * 32);

  sw_cmd_state_t state, state_nxt;
  op_code_t      op_q;
  logic [3:0]    dev_q;
  logic [3:0]    lat_cnt, lat_cnt_nxt;
  logic [15:0]   cmd_count;
  logic          err_busy, err_illegal;

  logic [3:0]    cmd_op, cmd_dev;
  logic          cmd_legal;
  logic          accept, capture, done_write;
  logic [NUM_OPS-1:0] op_stb;
  logic [IDX_W-1:0]   rd_base;

  assign cmd_op    = sw_write32_0[OP_MSB:OP_LSB];
  assign cmd_dev   = sw_write32_0[DEV_MSB:DEV_LSB];
  assign cmd_legal = (cmd_dev != 4'd0) && (cmd_dev <= 4'(NUM_FW)) && (cmd_op <= OP_MAX);

  // Bit offset of the addressed IP's slice in the read-back buses
  assign rd_base = IDX_W'(dev_q - 4'd1) << 5;

  // FSM state and latency counter
  always_ff @(posedge fw_clk) begin
    if (!fw_rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  // Next-state decode and the single-cycle events that drive the datapath
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    accept      = 1'b0;
    capture     = 1'b0;
    done_write  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sw_write32_0_wstb && cmd_legal) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_read_op(op_q)) begin
          if (READ_LAT == 1) begin
            capture   = 1'b1;
            state_nxt = ST_CAPTURE;
          end else begin
            lat_cnt_nxt = 4'(READ_LAT - 1);
            state_nxt   = ST_WAIT;
          end
        end else begin
          done_write = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Capture lands on the edge where the count would reach zero, so the
        // captured word is visible during the CAPTURE cycle itself
        if (lat_cnt == 4'd1) begin
          lat_cnt_nxt = 4'd0;
          capture     = 1'b1;
          state_nxt   = ST_CAPTURE;
        end else begin
          lat_cnt_nxt = lat_cnt - 4'd1;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the accepted command, drive enables/payload, capture read-back, count completions
  always_ff @(posedge fw_clk) begin
    if (!fw_rst_n) begin
      op_q             <= OP_W_RESET;
      dev_q            <= 4'd0;
      fw_dev_id_enable <= '0;
      sw_write24_0     <= 24'd0;
      sw_read32_0      <= 32'd0;
      cmd_count        <= 16'd0;
    end else begin
      if (accept) begin
        op_q             <= op_code_t'(cmd_op);
        dev_q            <= cmd_dev;
        fw_dev_id_enable <= NUM_FW'(1) << (cmd_dev - 4'd1);
        sw_write24_0     <= sw_write32_0[PAY_MSB:0];
      end
      if (capture) begin
        sw_read32_0 <= (op_q == OP_R_STATUS) ? fw_read_status32_bus[rd_base +: 32]
                                             : fw_read_data32_bus[rd_base +: 32];
      end
      if (capture || done_write) begin
        cmd_count <= cmd_count + 16'd1;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle still wins
  always_ff @(posedge fw_clk) begin
    if (!fw_rst_n) begin
      err_busy    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (state == ST_ISSUE && op_q == OP_W_RESET) begin
        err_busy    <= 1'b0;
        err_illegal <= 1'b0;
      end
      if (sw_write32_0_wstb && state != ST_IDLE) begin
        err_busy <= 1'b1;
      end
      if (sw_write32_0_wstb && state == ST_IDLE && !cmd_legal) begin
        err_illegal <= 1'b1;
      end
    end
  end

  // One-hot op strobe, high only in the ISSUE cycle
  always_comb begin
    op_stb = '0;
    if (state == ST_ISSUE) begin
      op_stb = NUM_OPS'(1) << op_q;
    end
  end

  assign fw_op_code_w_reset        = op_stb[OP_W_RESET];
  assign fw_op_code_w_cfg_static_0 = op_stb[OP_W_CFG_STATIC_0];
  assign fw_op_code_r_cfg_static_0 = op_stb[OP_R_CFG_STATIC_0];
  assign fw_op_code_w_cfg_array_0  = op_stb[OP_W_CFG_ARRAY_0];
  assign fw_op_code_r_cfg_array_0  = op_stb[OP_R_CFG_ARRAY_0];
  assign fw_op_code_w_cfg_array_1  = op_stb[OP_W_CFG_ARRAY_1];
  assign fw_op_code_r_cfg_array_1  = op_stb[OP_R_CFG_ARRAY_1];
  assign fw_op_code_r_data_array_0 = op_stb[OP_R_DATA_ARRAY_0];
  assign fw_op_code_r_data_array_1 = op_stb[OP_R_DATA_ARRAY_1];
  assign fw_op_code_r_status       = op_stb[OP_R_STATUS];
  assign fw_op_code_w_execute      = op_stb[OP_W_EXECUTE];

  // Software-visible decoder status word
  always_comb begin
    sw_read32_1                                = 32'd0;
    sw_read32_1[STS_BUSY_BIT]                  = (state != ST_IDLE);
    sw_read32_1[STS_ERR_BUSY]                  = err_busy;
    sw_read32_1[STS_ERR_ILLEGAL]               = err_illegal;
    sw_read32_1[STS_LAST_MSB:STS_LAST_LSB]     = {op_q, dev_q};
    sw_read32_1[STS_CNT_MSB:0]                 = cmd_count;
  end

endmodule

// File: doc/sw_cmd_decoder.md
Name: sw_cmd_decoder

Overview:
- Upstream command front-end for the per-IP firmware blocks of the CMS pixel-28 test firmware.
- Captures a software command word written over AXI and decodes byte 3 into a device-ID select and an op-code.
- Drives a one-cycle op-code strobe plus a level device enable to the addressed firmware IP, and feeds bytes 2..0 through.
- For read op-codes, waits a fixed latency, then captures the addressed IP's read-data and status words into software-visible read registers.

Parameters:
- NUM_FW, 15, number of attached firmware IPs; legal dev_id is 1..NUM_FW, max 15.
- READ_LAT, 2, cycles between op strobe and read-data capture, legal 1..15.

Ports:
- fw_clk  in  1  firmware clock, mapped to S_AXI_ACLK
- fw_rst_n  in  1  reset; synchronous, active-low, mapped to S_AXI_ARESETN
- sw_write32_0  in  32  command word; [31:28] op_code, [27:24] dev_id, [23:0] payload
- sw_write32_0_wstb  in  1  one-cycle pulse when software writes sw_write32_0
- fw_read_data32_bus  in  NUM_FW*32  read data from all IPs; slice k-1 belongs to dev_id k
- fw_read_status32_bus  in  NUM_FW*32  read status from all IPs, same slicing
- fw_dev_id_enable  out  NUM_FW  one-hot level enable of the addressed IP
- fw_op_code_w_reset, fw_op_code_w_cfg_static_0, fw_op_code_r_cfg_static_0, fw_op_code_w_cfg_array_0, fw_op_code_r_cfg_array_0, fw_op_code_w_cfg_array_1, fw_op_code_r_cfg_array_1, fw_op_code_r_data_array_0, fw_op_code_r_data_array_1, fw_op_code_r_status, fw_op_code_w_execute  out  1 each  one-cycle op strobes
- sw_write24_0  out  24  registered payload
- sw_read32_0  out  32  captured read data
- sw_read32_1  out  32  decoder status word

Behaviour:
- Op encoding:
  - 0x0 w_reset
  - 0x1 w_cfg_static_0, 0x2 r_cfg_static_0
  - 0x3 w_cfg_array_0, 0x4 r_cfg_array_0
  - 0x5 w_cfg_array_1, 0x6 r_cfg_array_1
  - 0x7 r_data_array_0, 0x8 r_data_array_1
  - 0x9 r_status, 0xA w_execute
  - 0xB..0xF illegal
- Reset values: every output is 0. FSM goes to IDLE, error flags cleared, cmd_count = 0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - On wstb with a legal command, register op, dev_id and payload, then go to ISSUE.
  - Illegal command (dev_id 0, dev_id > NUM_FW, or op >= 0xB): set sticky err_illegal, stay IDLE, drive no strobe, leave enables unchanged.
- ISSUE (cycle N+1 after wstb):
  - Exactly one op strobe is high for one cycle.
  - fw_dev_id_enable[dev_id-1] is high; sw_write24_0 is valid.
  - Write ops go to IDLE; cmd_count increments.
  - Read ops go to WAIT with the counter loaded to READ_LAT-1. If READ_LAT = 1, go straight to CAPTURE.
- WAIT: decrement the counter; go to CAPTURE when it reaches 0.
- CAPTURE (cycle N+1+READ_LAT):
  - Load sw_read32_0 from the addressed data slice, or from the status slice when op = r_status.
  - cmd_count increments; return to IDLE.
- fw_dev_id_enable and sw_write24_0 hold from ISSUE until the next legal command reaches ISSUE; they are not cleared on return to IDLE.
- wstb outside IDLE: command dropped, sticky err_busy set, no state change.
- wstb in the same cycle as a return to IDLE is also dropped (state is not IDLE in that cycle).
- sw_read32_1 layout:
  - [31] busy (state != IDLE)
  - [30] err_busy, [29] err_illegal
  - [23:16] last accepted {op, dev_id}
  - [15:0] cmd_count, wraps 0xFFFF -> 0x0000
- Error clear: a legal w_reset command clears both sticky flags during its ISSUE cycle.
- Reset mid-operation: the synchronous reset aborts any state and zeroes all outputs on the next edge. No capture happens after reset.

Decomposition:
- Package sw_cmd_pkg holds:
  - op-code enum op_code_t (4 bits, values above)
  - state enum sw_cmd_state_t
  - field position constants OP_MSB/LSB and DEV_MSB/LSB
  - status bit indices
- No sub-module is needed. The read-back slice mux is an inline indexed part-select.

Test Plan:
- Reset then idle: hold fw_rst_n = 0 for 3 cycles → all outputs 0, sw_read32_1 = 0x00000000.
- Write 0x14ABCDEF with wstb → one cycle later fw_op_code_w_cfg_static_0 = 1 for exactly 1 cycle, fw_dev_id_enable = 0x0008, sw_write24_0 = 0xABCDEF, cmd_count = 1.
- Write 0x93000000 with status slice 2 = 0xDEADBEEF (READ_LAT = 2) → r_status strobe at N+1, sw_read32_0 = 0xDEADBEEF at N+3, busy high for N+1..N+3.
- Write 0x73000000, then a second wstb at N+2 → second command dropped, err_busy = 1, only one strobe issued.
- Write 0xB1000000, then 0x10000000 (dev_id 0) → err_illegal = 1, no strobes. Then write 0x01000000 → w_reset strobe, both error flags cleared.
- Read op 0x45000000 with fw_rst_n pulsed low at N+2 → no capture, sw_read32_0 stays 0, FSM is IDLE after reset.
